// File: rtl/dmem_mmio.sv
// -----------------------------------------------------------------------------
// dmem_mmio
//   Data-side memory subsystem for a single-cycle core. Loads are answered
//   combinationally in the same cycle; stores land on the rising clock edge.
//   Addresses with ALUResult[31:16] == 16'hFFFF hit a small MMIO block; all
//   other addresses hit a word-addressed RAM that aliases modulo RAM_WORDS.
//
//   MMIO word offsets (ALUResult[15:0], low two bits ignored):
//     0x0000 LED     read/write
//     0x0004 CYCLE   read/write free-running counter
//     0x0008 TXDATA  write pushes the transmit FIFO, reads 0
//     0x000C STATUS  {overflow@8, count@6:2, empty@1, full@0};
//                    a write with WriteData[8]=1 clears overflow
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   reset      asynchronous active-low reset (RAM contents are kept)
//   MemWrite   store strobe qualifying ALUResult / WriteData
//   ALUResult  byte address from the core
//   WriteData  store data from the core
//   ReadData   combinational load data
//   leds       LED register contents
//   tx_data    FIFO head entry, 0 when the FIFO is empty
//   tx_valid   FIFO non-empty
//   tx_ready   consumer accepts the head when high together with tx_valid
// -----------------------------------------------------------------------------
module dmem_mmio #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [31:0] leds,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;  // count spans 0..FIFO_DEPTH inclusive

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic          sel_mmio;
  logic [13:0]   word_off;
  logic [AW-1:0] ram_idx;
  logic          sel_led;
  logic          sel_cycle;
  logic          sel_txdata;
  logic          sel_status;
  logic          unused_addr_bits;

  assign sel_mmio   = (ALUResult[31:16] == 16'hFFFF);
  assign word_off   = ALUResult[15:2];
  assign ram_idx    = ALUResult[AW+1:2];
  assign sel_led    = sel_mmio && (word_off == 14'd0);
  assign sel_cycle  = sel_mmio && (word_off == 14'd1);
  assign sel_txdata = sel_mmio && (word_off == 14'd2);
  assign sel_status = sel_mmio && (word_off == 14'd3);

  // Byte lane bits are not used: every access is a full word.
  assign unused_addr_bits = ^ALUResult[1:0];

  // ---------------------------------------------------------------------------
  // Storage: data RAM and FIFO entries (neither is reset)
  // ---------------------------------------------------------------------------
  logic [31:0] ram_mem  [RAM_WORDS];
  logic [31:0] fifo_mem [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // Register state
  // ---------------------------------------------------------------------------
  logic [31:0]   leds_q,   leds_d;
  logic [31:0]   cycle_q,  cycle_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          ovf_q,    ovf_d;

  logic ram_we;
  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic push_req;
  logic push_ok;
  logic push_drop;

  assign ram_we     = MemWrite && !sel_mmio;
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pop        = !fifo_empty && tx_ready;
  assign push_req   = MemWrite && sel_txdata;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign push_drop  = push_req && !push_ok;

  always_comb begin
    leds_d   = leds_q;
    cycle_d  = cycle_q + 32'd1;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (MemWrite && sel_led) begin
      leds_d = WriteData;
    end

    // A software write replaces this cycle's increment.
    if (MemWrite && sel_cycle) begin
      cycle_d = WriteData;
    end

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Setting wins over clearing.
    if (push_drop) begin
      ovf_d = 1'b1;
    end else if (MemWrite && sel_status && WriteData[8]) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds_q   <= '0;
      cycle_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      leds_q   <= leds_d;
      cycle_q  <= cycle_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_idx] <= WriteData;
    end
  end

  // Entries written while reset is held are harmless: count stays 0.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= WriteData;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [31:0] status_word;

  always_comb begin
    status_word      = '0;
    status_word[0]   = fifo_full;
    status_word[1]   = fifo_empty;
    status_word[6:2] = 5'(count_q);
    status_word[8]   = ovf_q;
  end

  always_comb begin
    ReadData = '0;
    if (sel_mmio) begin
      if (sel_led) begin
        ReadData = leds_q;
      end else if (sel_cycle) begin
        ReadData = cycle_q;
      end else if (sel_status) begin
        ReadData = status_word;
      end
    end else begin
      ReadData = ram_mem[ram_idx];
    end
  end

  assign leds     = leds_q;
  assign tx_valid = !fifo_empty;
  // Gated so an empty FIFO never exposes stale entries.
  assign tx_data  = fifo_empty ? 32'd0 : fifo_mem[rd_ptr_q];

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Data-side memory subsystem directly downstream of the single-cycle core; consumes ALUResult (address), WriteData and MemWrite, and returns ReadData in the same cycle.
- Contains word-addressed data RAM plus a small memory-mapped I/O region: LED register, free-running cycle counter, and a transmit FIFO drained over an external valid/ready port.

Parameters:
RAM_WORDS, 64, data RAM depth in 32-bit words (power of two, >=4)
FIFO_DEPTH, 4, transmit FIFO entries (power of two, 2..16)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
MemWrite  input  1  store strobe from core, qualifies WriteData/ALUResult
ALUResult  input  32  byte address from core
WriteData  input  32  store data from core
ReadData  output  32  load data to core, combinational from address
leds  output  32  LED register contents
tx_data  output  32  FIFO head entry; 0 when empty
tx_valid  output  1  FIFO non-empty
tx_ready  input  1  consumer accepts head when high with tx_valid

Behaviour:
- Address decode: ALUResult[31:16]==16'hFFFF selects MMIO, else RAM. ALUResult[1:0] ignored (word access only). RAM index = ALUResult[log2(RAM_WORDS)+1:2], aliases modulo RAM_WORDS.
- MMIO map (offset ALUResult[15:0]): 0x0000 LED (RW); 0x0004 CYCLE (RW); 0x0008 TXDATA (W push, reads 0); 0x000C STATUS (R; W clears overflow). All other MMIO offsets: read 0, write ignored.
- STATUS read: bit0 full, bit1 empty, bits[6:2] occupancy count (zero-extended), bit8 sticky overflow, other bits 0.
- Reads: ReadData purely combinational from current address and current state, zero-cycle latency; reflects pre-edge state in a cycle that also writes the same location.
- Writes: take effect at rising clk when MemWrite=1; visible to reads in the following cycle.
- RAM: not reset; contents undefined until written. Reset does not clear RAM.
- CYCLE: increments by 1 every cycle, wraps 0xFFFFFFFF->0. Write to CYCLE: value after edge = WriteData (no increment that cycle).
- FIFO push: MemWrite to TXDATA enqueues WriteData if count<FIFO_DEPTH, or if count==FIFO_DEPTH and a pop occurs the same cycle. Otherwise data is dropped and overflow bit set.
- FIFO pop: occurs when tx_valid && tx_ready at rising edge; head advances. tx_ready with tx_valid=0 has no effect.
- Simultaneous push+pop: count unchanged; FIFO order preserved.
- No bypass: push into empty FIFO raises tx_valid on the next cycle.
- tx_data and tx_valid are registered-state driven, stable while tx_valid && !tx_ready.
- Overflow bit: set on dropped push; cleared by STATUS write with WriteData[8]=1. Set has priority over clear in the same cycle (cannot coincide anyway since different addresses). Other STATUS write bits ignored.
- Pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
- Reset (reset=0, asynchronous): leds=0, CYCLE=0, FIFO empty (count=0, pointers 0), overflow=0, tx_valid=0, tx_data=0. ReadData follows the decode of reset state.
- Reset mid-operation: FIFO contents discarded immediately; pending pushes/pops that cycle are lost. Counting resumes from 0 on the first edge after release.

Test Plan:
- Release reset, store 0xDEADBEEF to 0x00000010, load 0x00000010 next cycle -> ReadData=0xDEADBEEF. Load 0x00000110 with RAM_WORDS=64 -> same value (alias).
- Store 0x000000A5 to 0xFFFF0000 -> leds=0x000000A5 after edge. Read 0xFFFF0000 -> 0xA5. Read 0xFFFF0020 -> 0.
- Hold reset low 3 cycles, release, read CYCLE after 10 edges -> 10. Write 0xFFFFFFFE, two edges later -> 0x00000000.
- tx_ready=0: push 1..5 to TXDATA -> STATUS=0x00000111 (full, count 4, overflow). Then tx_ready=1 -> tx_data sequence 1,2,3,4, tx_valid drops after 4th pop.
- With FIFO full and tx_ready=1, push 9 -> accepted, count stays 4, 9 appears last. Write STATUS 0x100 -> overflow cleared.
- Assert reset with FIFO holding 3 entries -> tx_valid=0 and tx_data=0 immediately (before next edge). STATUS read shows empty (0x00000002).
